// File: rtl/stream_mux_n.sv
// stream_mux_n: NUM_IN-to-1 valid/ready stream multiplexer with fixed or round-robin
// arbitration and a registered output stage. Optional stall counter: STREAM_MUX_N_STALL_CNT_EN.
module stream_mux_n #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 5,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_WIDTH-1:0]         out_chan
`ifdef STREAM_MUX_N_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_IN - 1);
  localparam logic [SEL_WIDTH-1:0] ONE_IDX  = SEL_WIDTH'(1);

  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic [SEL_WIDTH-1:0]  out_chan_r;
  logic [SEL_WIDTH-1:0]  rr_ptr_r;

  logic                  load_s;
  logic                  any_valid_s;
  logic                  xfer_s;
  logic                  found_s;
  logic                  hit_s;
  logic [NUM_IN-1:0]     grant_s;
  logic [SEL_WIDTH-1:0]  grant_idx_s;
  logic [SEL_WIDTH-1:0]  rr_next_s;
  logic [DATA_WIDTH-1:0] grant_data_s;

  // Channel index reached by stepping off channels upward from base, wrapping at NUM_IN.
  function automatic int wrap_idx(input int base, input int off);
    return (base + off >= NUM_IN) ? (base + off - NUM_IN) : (base + off);
  endfunction

  assign load_s      = !out_valid_r || out_ready;
  assign any_valid_s = |in_valid;

  // Grant selection: fixed index or first valid channel at/after rr_ptr.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    hit_s       = 1'b0;
    if (!mode) begin
      if ((sel <= LAST_IDX) && any_valid_s) begin
        grant_s[sel] = 1'b1;
        grant_idx_s  = sel;
        found_s      = 1'b1;
      end else begin
        grant_s     = '0;
        grant_idx_s = '0;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        hit_s   = !found_s && in_valid[wrap_idx(int'(rr_ptr_r), k)];
        found_s = found_s | hit_s;
        grant_s[wrap_idx(int'(rr_ptr_r), k)] = hit_s;
        grant_idx_s = hit_s ? SEL_WIDTH'(wrap_idx(int'(rr_ptr_r), k)) : grant_idx_s;
      end
    end
  end

  // One-hot data select for the granted channel.
  always_comb begin
    grant_data_s = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      grant_data_s = grant_data_s | (grant_s[k] ? in_data[k*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
  end

  // Ready is withheld during reset so no word is consumed and then discarded.
  assign in_ready  = (rst_n && load_s) ? grant_s : '0;
  assign xfer_s    = |(in_valid & in_ready);
  assign rr_next_s = (grant_idx_s == LAST_IDX) ? '0 : (grant_idx_s + ONE_IDX);

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_chan_r  <= '0;
      rr_ptr_r    <= '0;
    end else begin
      if (load_s) begin
        if (xfer_s) begin
          out_data_r  <= grant_data_s;
          out_chan_r  <= grant_idx_s;
          out_valid_r <= 1'b1;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
      if (xfer_s && mode) begin
        rr_ptr_r <= rr_next_s;
      end
    end
  end

`ifdef STREAM_MUX_N_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles the held word is back-pressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'h0000;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: scoreboard bench for stream_mux_n; directed scenarios then random traffic.
// Build with STREAM_MUX_N_STALL_CNT_EN to also check the stall counter.
module tb_stream_mux_n;
  localparam int DW = 32;
  localparam int N  = 5;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_chan;
`ifdef STREAM_MUX_N_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  stream_mux_n #(.DATA_WIDTH(DW), .NUM_IN(N), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan)
`ifdef STREAM_MUX_N_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: words expected at the output, in order.
  logic [SW+DW-1:0] exp_q[$];
  bit m_valid = 1'b0;
  int m_rr    = 0;
  int m_stall = 0;
  bit cur_exp_valid = 1'b0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = $urandom;
    return d;
  endfunction

  // Drive one cycle of inputs and predict its effect from the arbitration rules.
  task automatic step(input bit m, input int s, input logic [N-1:0] v, input bit ordy,
                      input logic [N*DW-1:0] d);
    int pick;
    bit load;
    logic [N-1:0] exp_x;
    @(negedge clk);
    rst_n = 1'b1; mode = m; sel = SW'(s); in_valid = v; out_ready = ordy; in_data = d;
    mon_en = 1'b1;
    #1;
`ifdef STREAM_MUX_N_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
    load = !m_valid || ordy;
    pick = -1;
    if (!m) begin
      if (s < N && v[s]) pick = s;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (pick < 0 && v[c]) pick = c;
      end
    end
    exp_x = '0;
    if (load && pick >= 0) exp_x[pick] = 1'b1;
    check("handshake", v & in_ready, exp_x);
    if (!load || v == '0 || (!m && s >= N)) check("in_ready_idle", in_ready, 0);
    cur_exp_valid = m_valid;
    if (m_valid && !ordy && m_stall < 65535) m_stall++;
    if (load) begin
      if (pick >= 0) begin
        exp_q.push_back({SW'(pick), d[pick*DW +: DW]});
        m_valid = 1'b1;
        if (m) m_rr = (pick + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_rr_ptr", dut.rr_ptr_r, 0);
    check("rst_in_ready", in_ready, 0);
    exp_q.delete();
    m_valid = 1'b0; m_rr = 0; m_stall = 0;
  endtask

  // Monitor: compares the presented word with the scoreboard head, pops on acceptance.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      check("out_valid", out_valid, cur_exp_valid);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_word: got word %0h on chan %0d, expected none", out_data, out_chan);
        end else begin
          check("out_data", out_data, exp_q[0][DW-1:0]);
          check("out_chan", out_chan, exp_q[0][DW +: SW]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int exp_seq[7] = '{0, 1, 2, 3, 4, 0, 1};
    logic [N*DW-1:0] d;
    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_chan", out_chan, 0);
    check("reset_in_ready", in_ready, 0);

    // Fixed select of channel 2 with a known word.
    d = rand_data();
    d[2*DW +: DW] = 32'hA5A5_A5A5;
    step(1'b0, 2, 5'b00100, 1'b1, d);
    @(posedge clk); #1;
    check("fixed_valid", out_valid, 1);
    check("fixed_data", out_data, 32'hA5A5_A5A5);
    check("fixed_chan", out_chan, 2);
    step(1'b0, 0, 5'b00000, 1'b1, rand_data());

    // Out-of-range select never grants.
    repeat (10) step(1'b0, 5, 5'b11111, 1'b1, rand_data());
    repeat (3) step(1'b0, 7, 5'b11111, 1'b1, rand_data());

    // Round-robin rotation from pointer 0.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 0, 5'b11111, 1'b1, rand_data());
      @(posedge clk); #1;
      check("rr_seq", out_chan, exp_seq[i]);
    end

    // Move pointer to 3, then wrap search finds channel 0.
    step(1'b1, 0, 5'b00100, 1'b1, rand_data());
    step(1'b1, 0, 5'b00011, 1'b1, rand_data());
    @(posedge clk); #1;
    check("rr_wrap_chan", out_chan, 0);
    check("rr_ptr_after_wrap", dut.rr_ptr_r, 1);
    step(1'b1, 0, 5'b00011, 1'b1, rand_data());
    @(posedge clk); #1;
    check("rr_next_chan", out_chan, 1);

    // Back-pressure for 4 cycles, then drain.
    repeat (4) step(1'b1, 0, 5'b11111, 1'b0, rand_data());
    step(1'b1, 0, 5'b00000, 1'b1, rand_data());
    @(posedge clk); #1;
    check("drain_valid", out_valid, 0);

    // Reset while a word is held, then resume on the first edge.
    step(1'b1, 0, 5'b11111, 1'b0, rand_data());
    pulse_reset();
    step(1'b1, 0, 5'b11111, 1'b1, rand_data());
    @(posedge clk); #1;
    check("resume_valid", out_valid, 1);
    check("resume_chan", out_chan, 0);

    // Random traffic with occasional resets.
    repeat (400) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7), N'($urandom_range(0, 31)),
           ($urandom_range(0, 3) != 0), rand_data());
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end
    step(1'b0, 0, 5'b00000, 1'b1, rand_data());
    step(1'b0, 0, 5'b00000, 1'b1, rand_data());
    @(negedge clk);
    mon_en = 1'b0;
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one sample word.
REQ-002 SHALL have parameter NUM_IN, default 5: number of input channels, legal range 2..16.
REQ-003 SHALL have parameter SEL_WIDTH, default 3: width of sel and out_chan, at least ceil(log2(NUM_IN)).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  NUM_IN*DATA_WIDTH  packed channel words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port in_valid  input  NUM_IN  per-channel valid.
REQ-008 SHALL have port in_ready  output  NUM_IN  per-channel ready.
REQ-009 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel  input  SEL_WIDTH  channel index used in fixed mode.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  registered selected word.
REQ-012 SHALL have port out_valid  output  1  out_data holds a word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port out_chan  output  SEL_WIDTH  source channel of out_data.

Function
REQ-015 SHALL define load = !out_valid || out_ready; a transfer on input i occurs when in_valid[i] && in_ready[i].
REQ-016 SHALL drive in_ready[i] = load && grant[i]; at most one grant bit is set in any cycle, and in_ready is combinational from load and the grant.
REQ-017 Fixed mode SHALL set grant[sel] = 1 when sel < NUM_IN; when sel >= NUM_IN, grant SHALL be all zero and no transfer occurs.
REQ-018 Round-robin mode SHALL grant the first channel with in_valid set, searching from rr_ptr upward and wrapping from NUM_IN-1 to 0.
REQ-019 After a round-robin transfer from channel g, rr_ptr SHALL become g+1, or 0 when g = NUM_IN-1; otherwise rr_ptr SHALL hold.
REQ-020 Fixed-mode transfers SHALL NOT change rr_ptr.
REQ-021 On a transfer, out_data, out_chan and out_valid=1 SHALL update at the next edge, giving 1-cycle latency.
REQ-022 Sustained throughput SHALL be one word per cycle while out_ready = 1.
REQ-023 When out_valid && out_ready and no transfer occurs, out_valid SHALL go 0 at the next edge.
REQ-024 When out_valid && !out_ready, out_data and out_chan SHALL hold and all in_ready SHALL be 0.
REQ-025 Changes to mode or sel SHALL affect only the arbitration of the current cycle; a word already registered is unaffected.
REQ-026 If no channel is valid, all in_ready SHALL be 0 and the output register SHALL NOT load.

Reset
REQ-027 While rst_n = 0, the block SHALL immediately clear out_valid, out_data, out_chan and rr_ptr to 0, without waiting for a clock edge.
REQ-028 Asserting rst_n mid-transfer SHALL discard the held word; no input transfer SHALL occur while rst_n = 0.
REQ-029 After rst_n deasserts, operation SHALL resume on the first rising edge.

Configuration
REQ-030 With macro STREAM_MUX_N_STALL_CNT_EN defined, the block SHALL add port stall_cnt  output  16, a counter cleared by reset that increments each cycle out_valid && !out_ready and saturates at 0xFFFF.
REQ-031 Without STREAM_MUX_N_STALL_CNT_EN, neither the stall_cnt port nor the counter logic SHALL exist; all other behaviour is identical.

Verification
REQ-032 Fixed mode, sel=2, in_valid=5'b00100, in_data ch2=0xA5A5A5A5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5A5A5A5, out_chan=2.
REQ-033 Fixed mode, sel=5 (NUM_IN=5), all valid -> in_ready=0 and out_valid stays 0 for 10 cycles.
REQ-034 Round-robin, all five valid, out_ready=1 for 7 cycles -> out_chan sequence 0,1,2,3,4,0,1 at one word per cycle.
REQ-035 Round-robin, rr_ptr=3, in_valid=5'b00011 -> channel 0 granted, then rr_ptr=1.
REQ-036 Word held, out_ready=0 for 4 cycles -> out_data stable, in_ready=0, stall_cnt +4 (macro on); then out_ready=1 -> drain on the next edge.
REQ-037 rst_n low for one cycle while out_valid=1 -> out_valid=0 and rr_ptr=0 without a clock edge; with out_ready=1 and input valid, transfers resume on the first edge after release.
